// File: rtl/jam_cost_server.sv
// Cost-table server and run controller for the JAM assignment engine: loads an 8x8 cost
// table, runs JAM against it and reports the result. Optional feature macro: ACCESS_CNT_EN.
module jam_cost_server #(
  parameter int unsigned TIMEOUT = 10000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [6:0]  In_Data,
  output logic        Jam_RST,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  input  logic        Valid,
  input  logic [9:0]  MinCost,
  input  logic [3:0]  MatchCount,
  output logic        Res_Valid,
  output logic [9:0]  Res_MinCost,
  output logic [3:0]  Res_MatchCount,
  output logic [23:0] Res_Cycles,
  output logic        Res_Timeout,
`ifdef ACCESS_CNT_EN
  output logic [15:0] Res_Access,
`endif
  output logic        Busy
);

  // Load stream: an entry transfers on any cycle with In_Valid && In_Ready.
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_e;

  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 1);
  localparam logic [23:0] TMO_VAL  = 24'(TIMEOUT);

  state_e      state_q, state_d;
  logic [6:0]  table_q [64];
  logic [5:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic        jam_rst_q;
  logic [9:0]  res_min_q, res_min_d;
  logic [3:0]  res_mc_q, res_mc_d;
  logic [23:0] res_cyc_q, res_cyc_d;
  logic        res_tmo_q, res_tmo_d;
  logic        wr_en;
  logic        capture;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    res_min_d = res_min_q;
    res_mc_d  = res_mc_q;
    res_cyc_d = res_cyc_q;
    res_tmo_d = res_tmo_q;
    wr_en     = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_LOAD: begin
        cnt_d = '0;
        if (In_Valid) begin
          wr_en = 1'b1;
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Valid takes priority over an expiring timeout in the same cycle.
        if (Valid) begin
          capture   = 1'b1;
          res_min_d = MinCost;
          res_mc_d  = MatchCount;
          res_cyc_d = cnt_q;
          res_tmo_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          capture   = 1'b1;
          res_min_d = '0;
          res_mc_d  = '0;
          res_cyc_d = TMO_VAL;
          res_tmo_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_DONE: begin
        state_d = S_LOAD;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_LOAD;
      idx_q     <= '0;
      cnt_q     <= '0;
      jam_rst_q <= 1'b1;
      res_min_q <= '0;
      res_mc_q  <= '0;
      res_cyc_q <= '0;
      res_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      jam_rst_q <= (state_d != S_RUN);
      res_min_q <= res_min_d;
      res_mc_q  <= res_mc_d;
      res_cyc_q <= res_cyc_d;
      res_tmo_q <= res_tmo_d;
    end
  end

  // Table is only written in LOAD, so JAM sees a frozen table for the whole run.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[idx_q] <= In_Data;
    end
  end

`ifdef ACCESS_CNT_EN
  logic [15:0] acc_q, acc_inc, res_acc_q;
  logic [5:0]  prev_wj_q;
  logic        acc_step;

  // cnt_q is zero only on the first RUN cycle, which always counts as an access.
  assign acc_step = (cnt_q == 24'd0) || ({W, J} != prev_wj_q);
  assign acc_inc  = (acc_q == 16'hFFFF) ? acc_q : acc_q + {15'd0, acc_step};

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q     <= '0;
      res_acc_q <= '0;
      prev_wj_q <= '0;
    end else begin
      prev_wj_q <= {W, J};
      acc_q     <= (state_q == S_RUN && state_d == S_RUN) ? acc_inc : 16'd0;
      if (capture) res_acc_q <= acc_inc;
    end
  end

  assign Res_Access = res_acc_q;
`endif

  assign Cost           = table_q[{W, J}];
  assign In_Ready       = (state_q == S_LOAD);
  assign Busy           = (state_q == S_RUN);
  assign Res_Valid      = (state_q == S_DONE);
  assign Jam_RST        = jam_rst_q;
  assign Res_MinCost    = res_min_q;
  assign Res_MatchCount = res_mc_q;
  assign Res_Cycles     = res_cyc_q;
  assign Res_Timeout    = res_tmo_q;

endmodule
